// File: rtl/toy_bus_pkg.sv
// Shared definitions for toy_bus merge-point logic.
// Holds the payload field widths, the per-channel payload width, and the
// state encoding of the packet-lock FSM used by the age arbiter.
package toy_bus_pkg;

    // Payload field widths (ack channel layout).
    localparam int TB_OPC_W  = 1;
    localparam int TB_DATA_W = 256;
    localparam int TB_SB_W   = 9;
    localparam int TB_ID_W   = 4;

    // opcode + data + sideband + src_id + tgt_id
    localparam int PLD_W_ACK = TB_OPC_W + TB_DATA_W + TB_SB_W + 2 * TB_ID_W;

    // Packet-lock FSM states.
    typedef enum logic [0:0] {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/toy_bus_age_arb_lock_n_chk.sv
// Protocol/invariant checker for toy_bus_age_arb_lock_n.
// Ports: clk, rst_n, in_vld, in_rdy, in_pld of the arbiter, plus its grant
// vector and age matrix. Contains only assertions.
module toy_bus_age_arb_lock_n_chk #(
    parameter int NUM_IN = 4,
    parameter int PLD_W  = 274
) (
    input logic                           clk,
    input logic                           rst_n,
    input logic [NUM_IN-1:0]              in_vld,
    input logic [NUM_IN-1:0]              in_rdy,
    input logic [NUM_IN*PLD_W-1:0]        in_pld,
    input logic [NUM_IN-1:0]              grant,
    input logic [NUM_IN-1:0][NUM_IN-1:0]  age_row
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        a_pld_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (in_vld[i] && !in_rdy[i]) |=>
                (!in_vld[i] || $stable(in_pld[i*PLD_W +: PLD_W])));
        for (genvar j = i + 1; j < NUM_IN; j++) begin : g_pair
            a_age_antisym: assert property (@(posedge clk) disable iff (!rst_n)
                (age_row[i][j] ^ age_row[j][i]) == 1'b1);
        end
    end

endmodule

// File: rtl/toy_bus_age_mtx_n.sv
// NUM_IN x NUM_IN age matrix.
// age_row[i][j] = 1 means input j is older than (beats) input i.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   update_en   : one-hot (or zero) input that completed a grant this cycle
//   age_row     : current matrix, row i = set of inputs that beat input i
// After reset the lowest index is the oldest. A granted input becomes the
// youngest: its row goes to all ones, its column is cleared.
module toy_bus_age_mtx_n #(
    parameter int NUM_IN = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_IN-1:0]              update_en,
    output logic [NUM_IN-1:0][NUM_IN-1:0]  age_row
);

    logic [NUM_IN-1:0][NUM_IN-1:0] age_q;
    logic [NUM_IN-1:0][NUM_IN-1:0] age_d;

    // Next-state of each matrix bit; diagonal pinned to zero.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NUM_IN; i++) begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (i == j) begin
                    age_d[i][j] = 1'b0;
                end else if (update_en[i]) begin
                    age_d[i][j] = 1'b1;
                end else if (update_en[j]) begin
                    age_d[i][j] = 1'b0;
                end else begin
                    age_d[i][j] = age_q[i][j];
                end
            end
        end
    end

    // Matrix register; reset pattern makes lower indices older.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IN; i++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    age_q[i][j] <= (j < i);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    assign age_row = age_q;

endmodule

// File: rtl/toy_bus_age_arb_lock_n.sv
// N-input to 1-output age-matrix arbiter for toy_bus channels.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_vld/in_rdy/in_last    : per-input handshake and last-beat flag
//   in_pld                   : flattened payloads, input i at [i*PLD_W +: PLD_W]
//   out_vld/out_rdy          : output handshake
//   out_pld/out_last         : selected beat
//   out_src_idx              : index of the input that produced the beat
// With LOCK_EN=1 a multi-beat packet keeps the grant until its last beat.
// With OUT_REG=1 a 2-entry skid buffer registers the output and breaks the
// out_rdy -> in_rdy path (in_rdy only depends on the registered full flag).
module toy_bus_age_arb_lock_n
    import toy_bus_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int PLD_W   = PLD_W_ACK,
    parameter int LOCK_EN = 1,
    parameter int OUT_REG = 1,
    parameter int IDX_W   = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN-1:0]         in_vld,
    output logic [NUM_IN-1:0]         in_rdy,
    input  logic [NUM_IN*PLD_W-1:0]   in_pld,
    input  logic [NUM_IN-1:0]         in_last,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [PLD_W-1:0]          out_pld,
    output logic                      out_last,
    output logic [IDX_W-1:0]          out_src_idx
);

    logic [NUM_IN-1:0][NUM_IN-1:0] age_row_s;
    logic [NUM_IN-1:0]             sel_s;
    logic [NUM_IN-1:0]             lock_oh_s;
    logic [NUM_IN-1:0]             grant_s;
    logic [NUM_IN-1:0]             update_en_s;
    logic                          ds_rdy_s;
    logic                          accept_s;
    logic [IDX_W-1:0]              gnt_idx_s;
    logic [PLD_W-1:0]              gnt_pld_s;
    logic                          gnt_last_s;

    lock_state_e                   state_q;
    lock_state_e                   state_d;
    logic [IDX_W-1:0]              lock_idx_q;
    logic [IDX_W-1:0]              lock_idx_d;

    toy_bus_age_mtx_n #(
        .NUM_IN (NUM_IN)
    ) u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .update_en (update_en_s),
        .age_row   (age_row_s)
    );

    // Oldest valid input: valid and no valid input beats it.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_s[i] = in_vld[i] & ~|(age_row_s[i] & in_vld);
        end
    end

    // Grant: arbitration result when idle, the locked input when locked.
    always_comb begin
        lock_oh_s             = '0;
        lock_oh_s[lock_idx_q] = 1'b1;
        if (state_q == LOCK_LOCKED) begin
            grant_s = lock_oh_s;
        end else begin
            grant_s = sel_s;
        end
    end

    assign in_rdy   = grant_s & {NUM_IN{ds_rdy_s}};
    assign accept_s = |(in_vld & in_rdy);

    // AND-OR mux of the granted input (all zero when nothing is granted).
    always_comb begin
        gnt_idx_s  = '0;
        gnt_pld_s  = '0;
        gnt_last_s = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            gnt_idx_s  = gnt_idx_s  | (IDX_W'(i) & {IDX_W{grant_s[i]}});
            gnt_pld_s  = gnt_pld_s  | (in_pld[i*PLD_W +: PLD_W] & {PLD_W{grant_s[i]}});
            gnt_last_s = gnt_last_s | (in_last[i] & grant_s[i]);
        end
    end

    // Age update: per beat without lock, only on the closing beat with lock.
    always_comb begin
        if (accept_s && ((LOCK_EN == 0) || gnt_last_s)) begin
            update_en_s = grant_s;
        end else begin
            update_en_s = '0;
        end
    end

    // Lock FSM next state; never leaves IDLE when locking is disabled.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            LOCK_IDLE: begin
                if ((LOCK_EN != 0) && accept_s && !gnt_last_s) begin
                    state_d    = LOCK_LOCKED;
                    lock_idx_d = gnt_idx_s;
                end else begin
                    state_d    = LOCK_IDLE;
                end
            end
            LOCK_LOCKED: begin
                if (accept_s && gnt_last_s) begin
                    state_d = LOCK_IDLE;
                end else begin
                    state_d = LOCK_LOCKED;
                end
            end
            default: begin
                state_d = LOCK_IDLE;
            end
        endcase
    end

    // Lock FSM state and locked index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOCK_IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    if (OUT_REG != 0) begin : g_skid
        // Entry 0 is the head and drives the outputs directly.
        logic [PLD_W-1:0] pld0_q, pld0_d, pld1_q, pld1_d;
        logic [IDX_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
        logic             last0_q, last0_d, last1_q, last1_d;
        logic             vld0_q, vld0_d, vld1_q, vld1_d;
        logic             pop_s;

        assign pop_s    = vld0_q & out_rdy;
        // Entry 1 occupied means full; push and pop on a full buffer cannot
        // happen because in_rdy is low then.
        assign ds_rdy_s = ~vld1_q;

        // Skid buffer next state for push / pop / push+pop.
        always_comb begin
            pld0_d  = pld0_q;
            pld1_d  = pld1_q;
            idx0_d  = idx0_q;
            idx1_d  = idx1_q;
            last0_d = last0_q;
            last1_d = last1_q;
            vld0_d  = vld0_q;
            vld1_d  = vld1_q;
            case ({accept_s, pop_s})
                2'b10: begin
                    if (vld0_q) begin
                        pld1_d  = gnt_pld_s;
                        idx1_d  = gnt_idx_s;
                        last1_d = gnt_last_s;
                        vld1_d  = 1'b1;
                    end else begin
                        pld0_d  = gnt_pld_s;
                        idx0_d  = gnt_idx_s;
                        last0_d = gnt_last_s;
                        vld0_d  = 1'b1;
                    end
                end
                2'b01: begin
                    pld0_d  = pld1_q;
                    idx0_d  = idx1_q;
                    last0_d = last1_q;
                    vld0_d  = vld1_q;
                    vld1_d  = 1'b0;
                end
                2'b11: begin
                    // Only reachable with exactly one entry held.
                    pld0_d  = gnt_pld_s;
                    idx0_d  = gnt_idx_s;
                    last0_d = gnt_last_s;
                end
                default: begin
                    vld0_d = vld0_q;
                end
            endcase
        end

        // Skid buffer storage registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pld0_q  <= '0;
                pld1_q  <= '0;
                idx0_q  <= '0;
                idx1_q  <= '0;
                last0_q <= 1'b0;
                last1_q <= 1'b0;
                vld0_q  <= 1'b0;
                vld1_q  <= 1'b0;
            end else begin
                pld0_q  <= pld0_d;
                pld1_q  <= pld1_d;
                idx0_q  <= idx0_d;
                idx1_q  <= idx1_d;
                last0_q <= last0_d;
                last1_q <= last1_d;
                vld0_q  <= vld0_d;
                vld1_q  <= vld1_d;
            end
        end

        assign out_vld     = vld0_q;
        assign out_pld     = pld0_q;
        assign out_last    = last0_q;
        assign out_src_idx = idx0_q;
    end else begin : g_comb
        assign ds_rdy_s    = out_rdy;
        assign out_vld     = |(in_vld & grant_s);
        assign out_pld     = gnt_pld_s;
        assign out_last    = gnt_last_s;
        assign out_src_idx = gnt_idx_s;
    end

endmodule

// File: tb/tb_toy_bus_age_arb_lock_n.sv
module tb_toy_bus_age_arb_lock_n;
    localparam int PW = 274;

    logic clk;
    logic rst_n;

    // DUT A: LOCK_EN=1, OUT_REG=0
    logic [3:0]      a_vld, a_rdy, a_last;
    logic [4*PW-1:0] a_pld;
    logic            a_ovld, a_ordy, a_olast;
    logic [PW-1:0]   a_opld;
    logic [1:0]      a_oidx;

    // DUT B: LOCK_EN=1, OUT_REG=1
    logic [3:0]      b_vld, b_rdy, b_last;
    logic [4*PW-1:0] b_pld;
    logic            b_ovld, b_ordy, b_olast;
    logic [PW-1:0]   b_opld;
    logic [1:0]      b_oidx;

    int n_chk;
    int n_fail;
    int b_seq;

    toy_bus_age_arb_lock_n #(.NUM_IN(4), .PLD_W(PW), .LOCK_EN(1), .OUT_REG(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_vld(a_vld), .in_rdy(a_rdy), .in_pld(a_pld),
        .in_last(a_last), .out_vld(a_ovld), .out_rdy(a_ordy), .out_pld(a_opld),
        .out_last(a_olast), .out_src_idx(a_oidx));

    toy_bus_age_arb_lock_n #(.NUM_IN(4), .PLD_W(PW), .LOCK_EN(1), .OUT_REG(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_vld(b_vld), .in_rdy(b_rdy), .in_pld(b_pld),
        .in_last(b_last), .out_vld(b_ovld), .out_rdy(b_ordy), .out_pld(b_opld),
        .out_last(b_olast), .out_src_idx(b_oidx));

    toy_bus_age_arb_lock_n_chk #(.NUM_IN(4), .PLD_W(PW)) u_chk_a (
        .clk(clk), .rst_n(rst_n), .in_vld(a_vld), .in_rdy(a_rdy), .in_pld(a_pld),
        .grant(u_dut_a.grant_s), .age_row(u_dut_a.u_age.age_row));

    toy_bus_age_arb_lock_n_chk #(.NUM_IN(4), .PLD_W(PW)) u_chk_b (
        .clk(clk), .rst_n(rst_n), .in_vld(b_vld), .in_rdy(b_rdy), .in_pld(b_pld),
        .grant(u_dut_b.grant_s), .age_row(u_dut_b.u_age.age_row));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pld_of(input int i);
        return PW'(32'hC0DE_0000) + PW'(i);
    endfunction

    task automatic set_b_pld();
        b_pld[0 +: PW] = PW'(b_seq);
        for (int i = 1; i < 4; i++) b_pld[i*PW +: PW] = pld_of(i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_vld = 4'b0000; a_last = 4'b0000; a_ordy = 1'b1;
        b_vld = 4'b0000; b_last = 4'b0000; b_ordy = 1'b0;
        for (int i = 0; i < 4; i++) a_pld[i*PW +: PW] = pld_of(i);
        b_seq = 0;
        set_b_pld();
        #12;
        n_chk++;
        if (a_ovld !== 1'b0 || a_rdy !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_a: ovld=%b rdy=%b, want ovld=0 rdy=0000", a_ovld, a_rdy);
        end
        n_chk++;
        if (b_ovld !== 1'b0 || b_olast !== 1'b0 || b_oidx !== 2'd0 || b_opld !== '0) begin
            n_fail++;
            $display("FAIL reset_b: ovld=%b last=%b idx=%0d pld=%h, want all 0",
                     b_ovld, b_olast, b_oidx, b_opld[31:0]);
        end
        n_chk++;
        if (b_rdy !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_b_rdy: got %b want 0000", b_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        a_vld = 4'b1111; a_last = 4'b1111; a_ordy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_chk++;
            if (a_ovld !== 1'b1 || a_oidx !== 2'(c % 4) || a_opld !== pld_of(c % 4)) begin
                n_fail++;
                $display("FAIL round_robin c%0d: ovld=%b idx=%0d, want ovld=1 idx=%0d",
                         c, a_ovld, a_oidx, c % 4);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_two_inputs();
        int seq_t[4];
        logic [3:0] exp_rdy;
        seq_t = '{1, 3, 1, 3};
        a_vld = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            exp_rdy = 4'b0001 << seq_t[c];
            @(negedge clk);
            n_chk++;
            if (a_oidx !== 2'(seq_t[c]) || a_rdy !== exp_rdy) begin
                n_fail++;
                $display("FAIL two_inputs c%0d: idx=%0d rdy=%b, want idx=%0d rdy=%b",
                         c, a_oidx, a_rdy, seq_t[c], exp_rdy);
            end
            @(posedge clk); #1;
        end
        a_vld = 4'b0000;
    endtask

    task automatic test_lock_packet();
        logic [3:0] v_t[4];
        logic [3:0] l_t[4];
        logic [3:0] r_t[4];
        logic [3:0] row2_t[4];
        int         i_t[4];
        v_t    = '{4'b0100, 4'b0101, 4'b0101, 4'b0001};
        l_t    = '{4'b0000, 4'b0000, 4'b0100, 4'b0001};
        r_t    = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
        row2_t = '{4'b0001, 4'b0001, 4'b0001, 4'b1011};
        i_t    = '{2, 2, 2, 0};
        for (int c = 0; c < 4; c++) begin
            a_vld = v_t[c]; a_last = l_t[c];
            @(negedge clk);
            n_chk++;
            if (a_ovld !== 1'b1 || a_oidx !== 2'(i_t[c]) || a_rdy !== r_t[c]
                || a_olast !== l_t[c][i_t[c]]) begin
                n_fail++;
                $display("FAIL lock_packet c%0d: ovld=%b idx=%0d rdy=%b last=%b, want 1 %0d %b %b",
                         c, a_ovld, a_oidx, a_rdy, a_olast, i_t[c], r_t[c], l_t[c][i_t[c]]);
            end
            n_chk++;
            if (u_dut_a.u_age.age_row[2] !== row2_t[c]) begin
                n_fail++;
                $display("FAIL lock_age_row2 c%0d: got %b want %b",
                         c, u_dut_a.u_age.age_row[2], row2_t[c]);
            end
            @(posedge clk); #1;
        end
        a_vld = 4'b0000;
    endtask

    task automatic test_lock_stall();
        logic [3:0] v_t[5];
        logic [3:0] l_t[5];
        logic [3:0] r_t[5];
        logic       o_t[5];
        int         i_t[5];
        v_t = '{4'b0101, 4'b0001, 4'b0001, 4'b0101, 4'b0001};
        l_t = '{4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0001};
        r_t = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        o_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        i_t = '{2, 0, 0, 2, 0};
        for (int c = 0; c < 5; c++) begin
            a_vld = v_t[c]; a_last = l_t[c];
            @(negedge clk);
            n_chk++;
            if (a_ovld !== o_t[c] || a_rdy !== r_t[c]) begin
                n_fail++;
                $display("FAIL lock_stall c%0d: ovld=%b rdy=%b, want ovld=%b rdy=%b",
                         c, a_ovld, a_rdy, o_t[c], r_t[c]);
            end
            if (o_t[c]) begin
                n_chk++;
                if (a_oidx !== 2'(i_t[c])) begin
                    n_fail++;
                    $display("FAIL lock_stall_idx c%0d: got %0d want %0d", c, a_oidx, i_t[c]);
                end
            end
            @(posedge clk); #1;
        end
        a_vld = 4'b0000;
    endtask

    task automatic test_skid();
        logic r_t[12];
        logic o_t[12];
        int   p_t[12];
        logic acc;
        r_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        o_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        p_t = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 0};
        b_last = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            b_vld  = (c < 10) ? 4'b0001 : 4'b0000;
            b_ordy = (c >= 4);
            set_b_pld();
            @(negedge clk);
            n_chk++;
            if (b_rdy !== {3'b000, r_t[c]} || b_ovld !== o_t[c]) begin
                n_fail++;
                $display("FAIL skid c%0d: rdy=%b ovld=%b, want rdy=%b ovld=%b",
                         c, b_rdy, b_ovld, {3'b000, r_t[c]}, o_t[c]);
            end
            if (o_t[c]) begin
                n_chk++;
                if (b_opld !== PW'(p_t[c]) || b_oidx !== 2'd0 || b_olast !== 1'b1) begin
                    n_fail++;
                    $display("FAIL skid_data c%0d: pld=%0d idx=%0d last=%b, want %0d 0 1",
                             c, b_opld[31:0], b_oidx, b_olast, p_t[c]);
                end
            end
            acc = b_vld[0] & b_rdy[0];
            @(posedge clk); #1;
            if (acc) b_seq++;
        end
        b_vld = 4'b0000;
    endtask

    task automatic test_reset_locked();
        b_ordy = 1'b0;
        b_vld  = 4'b0010; b_last = 4'b0000;
        @(negedge clk);
        n_chk++;
        if (b_rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL rl_first_rdy: got %b want 0010", b_rdy);
        end
        @(posedge clk); #1;
        b_vld = 4'b0000;
        @(negedge clk);
        n_chk++;
        if (b_ovld !== 1'b1 || b_oidx !== 2'd1 || b_rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL rl_locked: ovld=%b idx=%0d rdy=%b, want 1 1 0010",
                     b_ovld, b_oidx, b_rdy);
        end
        #2;
        rst_n = 1'b0;
        b_vld = 4'b1100; b_last = 4'b1100;
        #1;
        n_chk++;
        if (b_ovld !== 1'b0 || b_opld !== '0 || b_oidx !== 2'd0) begin
            n_fail++;
            $display("FAIL rl_async_reset: ovld=%b idx=%0d, want ovld=0 idx=0", b_ovld, b_oidx);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        b_ordy = 1'b1;
        @(negedge clk);
        n_chk++;
        if (b_rdy !== 4'b0100 || b_ovld !== 1'b0) begin
            n_fail++;
            $display("FAIL rl_after_reset: rdy=%b ovld=%b, want rdy=0100 ovld=0", b_rdy, b_ovld);
        end
        @(posedge clk); #1;
        b_vld = 4'b0000;
        @(negedge clk);
        n_chk++;
        if (b_ovld !== 1'b1 || b_oidx !== 2'd2 || b_olast !== 1'b1 || b_opld !== pld_of(2)) begin
            n_fail++;
            $display("FAIL rl_out: ovld=%b idx=%0d last=%b, want 1 2 1", b_ovld, b_oidx, b_olast);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_round_robin();
        test_two_inputs();
        test_lock_packet();
        test_lock_stall();
        test_skid();
        test_reset_locked();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
